multicycle_cpu_core: RTL

//   Parametrised multi-cycle successor to the single-cycle decode-only CPU.

---
 rtl/multicycle_cpu_core.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_cpu_core.sv
// Multi-cycle 16-bit-instruction CPU core: FETCH/DECODE/EXEC/MEM/WB sequencer,
// 4-entry register file, Z/N flags, one-deep link register, dmem and I/O ports.
module multicycle_cpu_core #(
    parameter int DATA_W  = 8,
    parameter int PC_W    = 8,
    parameter int DMEM_AW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [15:0]        imem_rdata,
    input  logic               imem_valid,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic               dmem_valid,
    input  logic [DATA_W-1:0]  in_port,
    output logic [DATA_W-1:0]  out_port,
    output logic               out_valid,
    output logic               instr_retired,
    output logic [PC_W-1:0]    pc_out
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_NAND, OP_SHL, OP_SHR, OP_OUT, OP_IN,
        OP_MOV, OP_BR, OP_BRC, OP_BSUB, OP_RET, OP_LOAD, OP_STORE, OP_LDI
    } op_t;

    state_t              state, state_nx;
    logic [15:0]         ir;
    logic [DATA_W-1:0]   opa, opb, res, alu_res;
    logic [DATA_W-1:0]   regs [4];
    logic [DATA_W-1:0]   out_q;
    logic [PC_W-1:0]     pc, lr, pc_nx;
    logic                z_flag, n_flag;
    op_t                 op;
    logic [1:0]          ra, rb;
    logic [DATA_W-1:0]   imm_ext;
    logic [PC_W-1:0]     target;
    logic                reg_we, flag_we;

    assign op      = op_t'(ir[15:12]);
    assign ra      = ir[11:10];
    assign rb      = ir[9:8];
    assign imm_ext = DATA_W'(ir[7:0]);
    assign target  = ir[PC_W-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nx;
    end

    // Next-state and port outputs
    always_comb begin
        state_nx      = state;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        out_valid     = 1'b0;
        instr_retired = 1'b0;
        case (state)
            S_FETCH:  begin
                imem_req = 1'b1;
                if (imem_valid) state_nx = S_DECODE;
            end
            S_DECODE: state_nx = S_EXEC;
            S_EXEC:   state_nx = (op == OP_LOAD || op == OP_STORE) ? S_MEM : S_WB;
            S_MEM:    begin
                dmem_req = 1'b1;
                if (dmem_valid) state_nx = S_WB;
            end
            S_WB:     begin
                instr_retired = 1'b1;
                out_valid     = (op == OP_OUT);
                state_nx      = S_FETCH;
            end
            default:  state_nx = S_FETCH;
        endcase
    end

    assign imem_addr  = pc;
    assign pc_out     = pc;
    assign out_port   = out_q;
    assign dmem_we    = (op == OP_STORE);
    assign dmem_addr  = DMEM_AW'(opb);
    assign dmem_wdata = opa;

    // ALU; shifts by >= DATA_W yield zero by language shift semantics
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = opa + opb;
            OP_SUB:  alu_res = opa - opb;
            OP_NAND: alu_res = ~(opa & opb);
            OP_SHL:  alu_res = opa << opb;
            OP_SHR:  alu_res = opa >> opb;
            OP_IN:   alu_res = in_port;
            OP_MOV:  alu_res = opb;
            OP_LDI:  alu_res = imm_ext;
            default: alu_res = '0;
        endcase
    end

    // Next pc and write enables for the WB edge
    always_comb begin
        pc_nx   = pc + PC_W'(1);
        reg_we  = 1'b0;
        flag_we = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_NAND, OP_SHL, OP_SHR: begin
                reg_we  = 1'b1;
                flag_we = 1'b1;
            end
            OP_IN, OP_MOV, OP_LOAD, OP_LDI: reg_we = 1'b1;
            OP_BR, OP_BSUB: pc_nx = target;
            OP_BRC: if (ir[8] ? n_flag : z_flag) pc_nx = target;
            OP_RET: pc_nx = lr;
            default: ;
        endcase
    end

    // Datapath: latch instruction, operands, result; commit architectural state at WB
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc     <= '0;
            lr     <= '0;
            z_flag <= 1'b0;
            n_flag <= 1'b0;
            out_q  <= '0;
            ir     <= '0;
            opa    <= '0;
            opb    <= '0;
            res    <= '0;
            for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH:  if (imem_valid) ir <= imem_rdata;
                S_DECODE: begin
                    opa <= regs[ra];
                    opb <= regs[rb];
                end
                S_EXEC:   res <= alu_res;
                S_MEM:    if (dmem_valid && op == OP_LOAD) res <= dmem_rdata;
                S_WB:     begin
                    pc <= pc_nx;
                    if (reg_we) regs[ra] <= res;
                    if (flag_we) begin
                        z_flag <= (res == '0);
                        n_flag <= res[DATA_W-1];
                    end
                    if (op == OP_OUT)  out_q <= opa;
                    if (op == OP_BSUB) lr    <= pc + PC_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
